// File: rtl/poly_adsr_mixer.sv
// Polyphonic ADSR envelope engine and voice mixer, one shared sequencer.
// Ports: clk, rst, sample_tick, gate, adsr, sample_in -> mix_out, mix_valid, env_out, active, busy, overrun.
module poly_adsr_mixer #(
  parameter int VOICES   = 4,
  parameter int BITSIZE  = 16,
  parameter int ENV_BITS = 8,
  parameter int ACC_BITS = 20,
  parameter int MIX_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_tick,
  input  logic [VOICES-1:0]           gate,
  input  logic [16*VOICES-1:0]        adsr,
  input  logic [BITSIZE*VOICES-1:0]   sample_in,
  output logic [BITSIZE-1:0]          mix_out,
  output logic                        mix_valid,
  output logic [ENV_BITS*VOICES-1:0]  env_out,
  output logic [VOICES-1:0]           active,
  output logic                        busy,
  output logic                        overrun
);

  localparam int LV  = $clog2(VOICES);
  localparam int VIW = (LV == 0) ? 1 : LV;
  localparam int CW  = $clog2(VOICES + 2);
  localparam int SW  = BITSIZE + LV + 1;
  localparam int PW  = BITSIZE + ENV_BITS + 1;

  localparam logic [CW-1:0] C_NV  = CW'(VOICES);
  localparam logic [CW-1:0] C_END = CW'(VOICES + 1);
  localparam logic [ACC_BITS-1:0] ACC_MAX = '1;
  localparam logic [ACC_BITS-1:0] INC_TOP = ACC_BITS'(1) << (ACC_BITS - 5);
  localparam logic signed [SW-1:0] SMAX =
    {{(LV + 2){1'b0}}, {(BITSIZE - 1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN =
    {{(LV + 2){1'b1}}, {(BITSIZE - 1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, ATTACK, DECAY, SUSTAIN, RELEASE
  } state_t;

  function automatic logic [ACC_BITS-1:0] inc_of(input logic [3:0] k);
    return INC_TOP >> k;
  endfunction

  state_t                  st  [VOICES];
  logic [ACC_BITS-1:0]     acc [VOICES];
  logic [VOICES-1:0]       cap_gate;
  logic [VOICES-1:0]       prev_gate;
  logic [16*VOICES-1:0]    cap_adsr;
  logic [BITSIZE*VOICES-1:0] cap_smp;
  logic [CW-1:0]           cnt;
  logic signed [SW-1:0]    sum;

  // cnt selects the voice being updated; the voice one behind it is mixed
  logic [VIW-1:0] uv;
  logic [VIW-1:0] pv;
  assign uv = VIW'(cnt);
  assign pv = VIW'(cnt - CW'(1));

  logic [15:0]         vp;
  state_t              st_c;
  logic [ACC_BITS-1:0] acc_c;
  logic                g_c;
  logic                rise_c;
  assign vp     = cap_adsr[16*uv +: 16];
  assign st_c   = st[uv];
  assign acc_c  = acc[uv];
  assign g_c    = cap_gate[uv];
  assign rise_c = cap_gate[uv] & ~prev_gate[uv];

  logic [ACC_BITS:0] add_a;
  logic [ACC_BITS:0] sub_d;
  logic [ACC_BITS:0] sub_r;
  assign add_a = {1'b0, acc_c} + {1'b0, inc_of(vp[15:12])};
  assign sub_d = {1'b0, acc_c} - {1'b0, inc_of(vp[11:8])};
  assign sub_r = {1'b0, acc_c} - {1'b0, inc_of(vp[3:0])};

  // sustain level: the 4-bit s repeated down from the MSB
  logic [ACC_BITS-1:0] tgt;
  always_comb begin
    tgt = '0;
    for (int j = 0; j < ACC_BITS; j++)
      tgt[ACC_BITS-1-j] = vp[7 - (j % 4)];
  end

  logic [ACC_BITS-1:0] att_acc;
  state_t              att_st;
  always_comb begin
    att_acc = add_a[ACC_BITS-1:0];
    att_st  = ATTACK;
    if (add_a >= {1'b0, ACC_MAX}) begin
      att_acc = ACC_MAX;
      att_st  = DECAY;
    end
  end

  logic [ACC_BITS-1:0] nacc;
  state_t              nst;
  always_comb begin
    nst  = st_c;
    nacc = acc_c;
    if (rise_c) begin
      nst  = att_st;
      nacc = att_acc;
    end else if (!g_c && (st_c == ATTACK || st_c == DECAY ||
                          st_c == SUSTAIN)) begin
      nst = RELEASE;
    end else begin
      unique case (st_c)
        ATTACK: begin
          nst  = att_st;
          nacc = att_acc;
        end
        DECAY: begin
          if (sub_d[ACC_BITS] || sub_d[ACC_BITS-1:0] <= tgt) begin
            nacc = tgt;
            nst  = SUSTAIN;
          end else begin
            nacc = sub_d[ACC_BITS-1:0];
          end
        end
        SUSTAIN: nacc = tgt;
        RELEASE: begin
          if (sub_r[ACC_BITS] || sub_r[ACC_BITS-1:0] == '0) begin
            nacc = '0;
            nst  = IDLE;
          end else begin
            nacc = sub_r[ACC_BITS-1:0];
          end
        end
        default: begin
          nacc = '0;
          nst  = IDLE;
        end
      endcase
    end
  end

  logic [ENV_BITS-1:0]      env_p;
  logic signed [BITSIZE-1:0] smp_p;
  logic signed [ENV_BITS:0] envs;
  logic signed [PW-1:0]     prod;
  logic signed [SW-1:0]     prod_s;
  assign env_p  = acc[pv][ACC_BITS-1 -: ENV_BITS];
  assign smp_p  = cap_smp[BITSIZE*pv +: BITSIZE];
  assign envs   = {1'b0, env_p};
  assign prod   = smp_p * envs;
  assign prod_s = SW'(prod >>> ENV_BITS);

  logic signed [SW-1:0]  avg;
  logic [BITSIZE-1:0]    mix_c;
  assign avg = sum >>> LV;
  always_comb begin
    mix_c = '0;
    if (MIX_MODE == 0) begin
      if (sum > SMAX)
        mix_c = {1'b0, {(BITSIZE - 1){1'b1}}};
      else if (sum < SMIN)
        mix_c = {1'b1, {(BITSIZE - 1){1'b0}}};
      else
        mix_c = BITSIZE'(sum);
    end else begin
      mix_c = BITSIZE'(avg);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) begin
        st[i]  <= IDLE;
        acc[i] <= '0;
      end
      cap_gate  <= '0;
      prev_gate <= '0;
      cap_adsr  <= '0;
      cap_smp   <= '0;
      cnt       <= '0;
      sum       <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      env_out   <= '0;
      active    <= '0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      if (sample_tick && busy)
        overrun <= 1'b1;
      if (sample_tick && !busy) begin
        prev_gate <= cap_gate;
        cap_gate  <= gate;
        cap_adsr  <= adsr;
        cap_smp   <= sample_in;
        cnt       <= '0;
        sum       <= '0;
        busy      <= 1'b1;
      end else if (busy) begin
        cnt <= cnt + CW'(1);
        if (cnt < C_NV) begin
          st[uv]  <= nst;
          acc[uv] <= nacc;
          env_out[ENV_BITS*uv +: ENV_BITS] <=
            nacc[ACC_BITS-1 -: ENV_BITS];
          active[uv] <= (nst != IDLE);
        end
        if (cnt != '0 && cnt <= C_NV)
          sum <= sum + prod_s;
        if (cnt == C_END) begin
          mix_out   <= mix_c;
          mix_valid <= 1'b1;
          busy      <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/poly_adsr_mixer.md
Name: poly_adsr_mixer

Overview:
- Multi-voice successor to the single-voice envelope/multiplier path.
- Holds VOICES independent ADSR envelope engines on one system clock. Each engine is time-multiplexed and advanced once per audio sample tick.
- Scales each voice's oscillator sample by its envelope, then sums all voices into one BITSIZE mix word for i2s_tx.
- Mix can saturate or average across voices (MIX_MODE).

Parameters:
- VOICES, 4, number of voices (≥1, power of two).
- BITSIZE, 16, signed sample width in and out.
- ENV_BITS, 8, envelope output width (≤ ACC_BITS-4).
- ACC_BITS, 20, per-voice envelope accumulator width (≥ 20).
- MIX_MODE, 0, 0 = saturate sum to BITSIZE; 1 = arithmetic sum >>> log2(VOICES).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle strobe per audio sample.
- gate  in  VOICES  per-voice note gate.
- adsr  in  16*VOICES  per voice {a,d,s,r}, 4 bits each; voice v at [16v+15:16v].
- sample_in  in  BITSIZE*VOICES  signed oscillator samples; voice v at [BITSIZE*v +: BITSIZE].
- mix_out  out  BITSIZE  signed mixed sample.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- env_out  out  ENV_BITS*VOICES  current envelope per voice.
- active  out  VOICES  voice state ≠ IDLE.
- busy  out  1  sequencer processing a tick.
- overrun  out  1  sticky; set when a tick arrives while busy; cleared only by rst.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All voices go to IDLE; all accumulators = 0.
  - Gate history = 0; mix_out = 0; mix_valid = 0; busy = 0; overrun = 0; env_out = 0; active = 0.
  - rst mid-sequence aborts the sequence; no mix_valid is produced for it.
- Tick capture and sequencing:
  - At a tick cycle T0 with busy=0, sample_in, gate and adsr are captured and busy goes to 1.
  - Voice v is updated at cycle T0+1+v.
  - mix_out and a mix_valid pulse appear at cycle T0+VOICES+2; busy drops in that same cycle.
  - A tick while busy=1 is ignored and sets overrun.
- Rate: inc(k) = 2^(ACC_BITS-5-k), for k = 0..15.
- Sustain target: s replicated across ACC_BITS, MSB-aligned (e.g. s=8 with ACC_BITS=20 gives 0x88888).
- Envelope output: env = acc[ACC_BITS-1 -: ENV_BITS].
- Gate rising edge (captured gate=1 and previous captured gate=0):
  - Voice enters ATTACK from any state, including RELEASE and ATTACK.
  - acc is retained (no restart from 0).
  - Rising edge takes priority over every other transition in that update.
- Per-voice state machine (one update per tick):
  - ATTACK: acc += inc(a). If the result ≥ 2^ACC_BITS-1, acc = max and state → DECAY.
  - DECAY: acc -= inc(d). If the result ≤ target, or underflows, acc = target and state → SUSTAIN.
  - SUSTAIN: acc = target every tick, so live changes to s apply immediately.
  - Gate low in ATTACK, DECAY or SUSTAIN → RELEASE. The acc update for that tick is skipped.
  - RELEASE: acc -= inc(r). If the result ≤ 0, acc = 0 and state → IDLE.
  - IDLE: acc = 0.
  - A held-high gate in RELEASE or IDLE without a rising edge does nothing.
- Arithmetic:
  - Per voice: prod = sample_in × {1'b0, env}, signed, then >>> ENV_BITS (floor).
  - Accumulate in BITSIZE+log2(VOICES)+1 bits.
  - MIX_MODE 0: clamp to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
  - MIX_MODE 1: sum >>> log2(VOICES).
- env_out and active update at each voice's processing cycle.

Test Plan:
- Attack: VOICES=4, ACC_BITS=20, adsr={0,0,8,0}, gate0 0→1, one tick per 1024 clk.
  - env_out[0] rises by 8 per tick.
  - At tick 32: env=255, state DECAY.
- Decay/sustain: continue the attack scenario.
  - 15 ticks later: env=136 (0x88), stays 136.
  - Change s to 4: env=68 on the next tick.
- Release: gate0 low from s=8 sustain.
  - Voice reaches IDLE after 18 ticks; env=0, active[0]=0.
  - Re-raise gate at tick 5 of release: ATTACK resumes from the current acc (env ≈ 0x60) with no drop to 0.
- Mix: all voices at env=255.
  - sample_in = +20000 each:
    - MIX_MODE 0: mix_out = 32767 (sum 79684).
    - MIX_MODE 1: mix_out = 19921.
  - sample_in = -20000 each:
    - MIX_MODE 0: mix_out = -32768.
    - MIX_MODE 1: mix_out = -19922.
- Timing and overrun: tick at T0, second tick at T0+2.
  - mix_valid exactly once, at T0+6.
  - overrun=1 and stays 1 until rst.
- Reset mid-sequence: rst at T0+3.
  - No mix_valid pulse.
  - All outputs 0.
  - The next tick sequences normally.
